// File: rtl/seven_segment_decoder.sv
// Recovers a byte from two 7-segment digit patterns using a stability filter and a valid/ready holding register.
// Define SEG_ACTIVE_LOW_EN to invert both segment buses before sampling (common-anode wiring).
module seven_segment_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] input_segment1,
    input  logic [6:0] input_segment2,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_pulse,
    output logic [1:0] err_mask,
    output logic       overrun
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] ST_TRACK = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [13:0]      pair_in;
    logic [13:0]      sample_q, sample_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [0:0]       state_q, state_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             err_pulse_q, err_pulse_d;
    logic [1:0]       err_mask_q, err_mask_d;
    logic             overrun_q, overrun_d;
    logic             fire;
    logic [4:0]       dig1, dig2;

`ifdef SEG_ACTIVE_LOW_EN
    assign pair_in = ~{input_segment2, input_segment1};
`else
    assign pair_in = {input_segment2, input_segment1};
`endif

    // Returns {legal, nibble}; anything outside the table (including blank) is illegal.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h7E: r = 5'h10;
            7'h30: r = 5'h11;
            7'h6D: r = 5'h12;
            7'h79: r = 5'h13;
            7'h33: r = 5'h14;
            7'h5B: r = 5'h15;
            7'h5F: r = 5'h16;
            7'h70: r = 5'h17;
            7'h7F: r = 5'h18;
            7'h7B: r = 5'h19;
            7'h77: r = 5'h1A;
            7'h1F: r = 5'h1B;
            7'h4E: r = 5'h1C;
            7'h3D: r = 5'h1D;
            7'h4F: r = 5'h1E;
            7'h47: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    assign dig1 = seg_decode(sample_q[6:0]);
    assign dig2 = seg_decode(sample_q[13:7]);

    always_comb begin
        sample_d = pair_in;
        count_d  = count_q;
        state_d  = state_q;
        fire     = 1'b0;
        if (pair_in != sample_q) begin
            count_d = '0;
            state_d = ST_TRACK;
        end else if (state_q == ST_TRACK) begin
            if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
            // sample_q already matched at the previous edge, so this edge completes the run
            if (count_q >= CNT_LAST) begin
                fire    = 1'b1;
                state_d = ST_HOLD;
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q & ~out_ready;
        err_pulse_d = 1'b0;
        err_mask_d  = '0;
        overrun_d   = overrun_q;
        if (fire && (sample_q != '0)) begin
            if (!dig1[4] || !dig2[4]) begin
                err_pulse_d = 1'b1;
                err_mask_d  = {~dig2[4], ~dig1[4]};
            end else if (!out_valid_q || out_ready) begin
                out_data_d  = {dig2[3:0], dig1[3:0]};
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_TRACK;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_pulse_q <= 1'b0;
            err_mask_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            sample_q    <= sample_d;
            count_q     <= count_d;
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            err_pulse_q <= err_pulse_d;
            err_mask_q  <= err_mask_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err_pulse = err_pulse_q;
    assign err_mask  = err_mask_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Scoreboard bench for seven_segment_decoder: expected bytes queued at stimulus, checked on each transfer.
// Segment values are given in active-high form and inverted on drive when SEG_ACTIVE_LOW_EN is defined.
module tb_seven_segment_decoder;

    localparam int unsigned STABLE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] input_segment1;
    logic [6:0] input_segment2;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       err_pulse;
    logic [1:0] err_mask;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    seven_segment_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk            (clk),
        .reset          (reset),
        .input_segment1 (input_segment1),
        .input_segment2 (input_segment2),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .err_pulse      (err_pulse),
        .err_mask       (err_mask),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    // Each accepted transfer must match the oldest expected byte.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_transfer: got out_data=%h, expected no transfer", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) $display("FAIL transfer_data: got %h, expected %h", out_data, e);
                else n_pass++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pair(input logic [6:0] s2, input logic [6:0] s1);
`ifdef SEG_ACTIVE_LOW_EN
        input_segment2 = ~s2;
        input_segment1 = ~s1;
`else
        input_segment2 = s2;
        input_segment1 = s1;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        out_ready = 1'b1;
        drive_pair(7'h00, 7'h00);
        repeat (3) cyc();
        n_checks++; if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h, expected 00", out_data); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, expected 0", out_valid); else n_pass++;
        n_checks++; if (err_pulse !== 1'b0) $display("FAIL reset_err_pulse: got %b, expected 0", err_pulse); else n_pass++;
        n_checks++; if (err_mask !== 2'b00) $display("FAIL reset_err_mask: got %b, expected 00", err_mask); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b, expected 0", overrun); else n_pass++;
        reset = 1'b0;
        begin
            int nv = 0, np = 0;
            for (int i = 0; i < 8; i++) begin
                cyc();
                if (out_valid === 1'b1) nv++;
                if (err_pulse === 1'b1) np++;
            end
            n_checks++; if (nv != 0) $display("FAIL blank_after_reset_valid: got %0d valid cycles, expected 0", nv); else n_pass++;
            n_checks++; if (np != 0) $display("FAIL blank_after_reset_err: got %0d pulses, expected 0", np); else n_pass++;
        end
    endtask

    task automatic test_single_emit();
        int rise = 0, nv = 0;
        drive_pair(7'h7E, 7'h30);
        exp_q.push_back(8'h01);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (out_valid === 1'b1) begin
                nv++;
                if (rise == 0) rise = i;
            end
        end
        n_checks++; if (rise != int'(STABLE + 1)) $display("FAIL single_rise_edge: got edge %0d, expected %0d", rise, STABLE + 1); else n_pass++;
        n_checks++; if (nv != 1) $display("FAIL single_valid_cycles: got %0d, expected 1", nv); else n_pass++;
    endtask

    task automatic test_glitch_filter();
        int nv = 0;
        drive_pair(7'h6D, 7'h79);
        repeat (2) begin cyc(); if (out_valid === 1'b1) nv++; end
        drive_pair(7'h4F, 7'h47);
        exp_q.push_back(8'hEF);
        repeat (10) begin cyc(); if (out_valid === 1'b1) nv++; end
        n_checks++; if (nv != 1) $display("FAIL glitch_valid_cycles: got %0d, expected 1", nv); else n_pass++;
    endtask

    task automatic test_threshold();
        int nv = 0;
        drive_pair(7'h5B, 7'h5B);
        repeat (STABLE) begin cyc(); if (out_valid === 1'b1) nv++; end
        drive_pair(7'h00, 7'h00);
        repeat (6) begin cyc(); if (out_valid === 1'b1) nv++; end
        n_checks++; if (nv != 0) $display("FAIL short_hold_valid: got %0d, expected 0", nv); else n_pass++;
        nv = 0;
        drive_pair(7'h5B, 7'h5B);
        exp_q.push_back(8'h55);
        repeat (STABLE + 1) begin cyc(); if (out_valid === 1'b1) nv++; end
        drive_pair(7'h00, 7'h00);
        repeat (6) begin cyc(); if (out_valid === 1'b1) nv++; end
        n_checks++; if (nv != 1) $display("FAIL exact_hold_valid: got %0d, expected 1", nv); else n_pass++;
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        drive_pair(7'h77, 7'h5B);
        exp_q.push_back(8'hA5);
        repeat (8) cyc();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL hold_valid: got %b, expected 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 8'hA5) $display("FAIL hold_data: got %h, expected a5", out_data); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL overrun_early: got %b, expected 0", overrun); else n_pass++;
        drive_pair(7'h79, 7'h4E);
        repeat (8) cyc();
        n_checks++; if (out_valid !== 1'b1) $display("FAIL drop_valid: got %b, expected 1", out_valid); else n_pass++;
        n_checks++; if (out_data !== 8'hA5) $display("FAIL drop_data: got %h, expected a5", out_data); else n_pass++;
        n_checks++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b, expected 1", overrun); else n_pass++;
        out_ready = 1'b1;
        cyc();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL drain_valid: got %b, expected 0", out_valid); else n_pass++;
        repeat (4) cyc();
        n_checks++; if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %b, expected 1", overrun); else n_pass++;
    endtask

    task automatic test_illegal();
        logic [6:0] s2_t[3] = '{7'h7E, 7'h00, 7'h01};
        logic [6:0] s1_t[3] = '{7'h01, 7'h30, 7'h01};
        logic [1:0] m_t[3]  = '{2'b01, 2'b10, 2'b11};
        for (int k = 0; k < 3; k++) begin
            int np = 0, nv = 0, stray = 0;
            logic [1:0] seen = 2'b00;
            drive_pair(s2_t[k], s1_t[k]);
            repeat (10) begin
                cyc();
                if (err_pulse === 1'b1) begin np++; seen = err_mask; end
                else if (err_mask !== 2'b00) stray++;
                if (out_valid === 1'b1) nv++;
            end
            n_checks++; if (np != 1) $display("FAIL illegal%0d_pulses: got %0d, expected 1", k, np); else n_pass++;
            n_checks++; if (seen !== m_t[k]) $display("FAIL illegal%0d_mask: got %b, expected %b", k, seen, m_t[k]); else n_pass++;
            n_checks++; if (nv != 0) $display("FAIL illegal%0d_valid: got %0d, expected 0", k, nv); else n_pass++;
            n_checks++; if (stray != 0) $display("FAIL illegal%0d_mask_idle: got %0d nonzero cycles, expected 0", k, stray); else n_pass++;
        end
        begin
            int np = 0, nv = 0;
            drive_pair(7'h00, 7'h00);
            repeat (10) begin
                cyc();
                if (err_pulse === 1'b1) np++;
                if (out_valid === 1'b1) nv++;
            end
            n_checks++; if (np != 0) $display("FAIL blank_pulses: got %0d, expected 0", np); else n_pass++;
            n_checks++; if (nv != 0) $display("FAIL blank_valid: got %0d, expected 0", nv); else n_pass++;
        end
    endtask

    task automatic test_reset_midcount();
        int rise = 0, nv = 0;
        drive_pair(7'h30, 7'h30);
        repeat (3) cyc();
        reset = 1'b1;
        repeat (2) begin
            cyc();
            n_checks++;
            if ({out_data, out_valid, err_pulse, err_mask, overrun} !== 13'h0)
                $display("FAIL midreset_outputs: got data=%h valid=%b err=%b mask=%b ovr=%b, expected all 0",
                         out_data, out_valid, err_pulse, err_mask, overrun);
            else n_pass++;
        end
        reset = 1'b0;
        exp_q.push_back(8'h11);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (out_valid === 1'b1) begin
                nv++;
                if (rise == 0) rise = i;
            end
        end
        n_checks++; if (rise != int'(STABLE + 1)) $display("FAIL release_rise_edge: got edge %0d, expected %0d", rise, STABLE + 1); else n_pass++;
        n_checks++; if (nv != 1) $display("FAIL release_valid_cycles: got %0d, expected 1", nv); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nv = 0;
        drive_pair(7'h33, 7'h33);
        exp_q.push_back(8'h44);
        for (int i = 1; i <= 16; i++) begin
            if (i == 7) drive_pair(7'h00, 7'h00);
            if (i == 8) begin
                drive_pair(7'h33, 7'h33);
                exp_q.push_back(8'h44);
            end
            cyc();
            if (out_valid === 1'b1) nv++;
        end
        n_checks++; if (nv != 2) $display("FAIL reemit_valid_cycles: got %0d, expected 2", nv); else n_pass++;
    endtask

`ifdef SEG_ACTIVE_LOW_EN
    task automatic test_active_low();
        int nv = 0, np = 0;
        input_segment2 = 7'h00;
        input_segment1 = 7'h01;
        exp_q.push_back(8'h80);
        repeat (10) begin cyc(); if (out_valid === 1'b1) nv++; end
        n_checks++; if (nv != 1) $display("FAIL active_low_valid: got %0d, expected 1", nv); else n_pass++;
        nv = 0;
        input_segment2 = 7'h7F;
        input_segment1 = 7'h7F;
        repeat (10) begin
            cyc();
            if (out_valid === 1'b1) nv++;
            if (err_pulse === 1'b1) np++;
        end
        n_checks++; if (nv != 0 || np != 0) $display("FAIL active_low_blank: got valid=%0d pulses=%0d, expected 0/0", nv, np); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_emit();
        test_glitch_filter();
        test_threshold();
        test_overrun();
        test_illegal();
        test_reset_midcount();
        test_back_to_back();
`ifdef SEG_ACTIVE_LOW_EN
        test_active_low();
`endif
        repeat (3) cyc();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drained: got %0d outstanding, expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seven_segment_decoder.md
Name: seven_segment_decoder

Overview:
Reverse path of the board's hex-to-7-segment encoding: watches two 7-segment digit patterns and recovers the 8-bit value they display. A stability filter qualifies each pattern pair. The block then decodes it, raises an illegal-pattern error where needed, and presents the byte on a valid/ready output with a single holding register. It sits between a scanned display bus or probe point and the byte-consuming logic.

Parameters:
STABLE_CYCLES, 4, consecutive equal samples needed before decode; legal range 2..255.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
input_segment1  in  7  low-nibble digit pattern; bit6=a … bit0=g; active-high
input_segment2  in  7  high-nibble digit pattern; same encoding
out_data  out  8  decoded byte, {digit2, digit1}
out_valid  out  1  out_data holds an unconsumed byte
out_ready  in  1  consumer accepts the byte at this edge when out_valid=1
err_pulse  out  1  one-cycle pulse: a qualified pair contained an illegal pattern
err_mask  out  2  bit0=digit1 illegal, bit1=digit2 illegal; valid while err_pulse=1, else 0
overrun  out  1  sticky: a qualified byte was dropped because the holding register was full

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: out_data=0, out_valid=0, err_pulse=0, err_mask=0, overrun=0. The sample register clears to 14'b0, the counter to 0, and the FSM to TRACK.
- Decode table (hex: pattern): 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:7B A:77 B:1F C:4E D:3D E:4F F:47. Any other 7-bit value is illegal.
- Input stage: {input_segment2, input_segment1} is registered into sample_q every edge.
- Change detection: a change is an edge where the incoming pair differs from sample_q. On a change, counter←0 and FSM→TRACK.
- TRACK state:
  - counter increments on each edge with no change.
  - When the pair has been sampled unchanged at STABLE_CYCLES consecutive edges, a decode event fires and FSM→HOLD.
  - Timing: pair first sampled at edge 1 → event effect visible after edge STABLE_CYCLES+1 (STABLE_CYCLES=4: out_valid rises after edge 5).
- HOLD state: no further events until a change. A glitch that returns to the same pair re-qualifies and re-emits.
- Counter width is ceil(log2(STABLE_CYCLES+1)). The counter saturates and never wraps.
- Decode event, by pair content:
  - Both digits blank (7'h00): ignored. No data, no error.
  - Any illegal digit, including one blank digit: err_pulse=1 for exactly one cycle, err_mask flags the offending digits, no data load, out_valid unchanged.
  - Both digits legal: byte goes to the holding register under the rules below.
- Holding register and handshake:
  - Transfer occurs at an edge where out_valid & out_ready; out_valid clears unless reloaded on the same edge.
  - Event while out_valid=0, or while out_valid=1 with out_ready=1 on the same edge: load out_data, out_valid=1, no overrun.
  - Event while out_valid=1 and out_ready=0: new byte dropped, out_data unchanged, overrun←1. overrun clears only on reset.
  - out_data is stable while out_valid=1.
- Power-up case: after reset, a steady non-blank input differs from the cleared sample_q, so it is treated as a change and emits once.
- Reset mid-count or mid-HOLD aborts the operation. Any pending byte is lost and all outputs return to reset values next cycle.

Optional Feature:
SEG_ACTIVE_LOW_EN
- Defined: both input buses are inverted before sampling (common-anode wiring). All table and blank rules apply to the inverted value, so raw 7'h7F on both digits means blank.
- Undefined: inputs are used as-is (active-high).

Test Plan:
1. Reset; input_segment2=7E, input_segment1=30 held 10 cycles; out_ready=1 → out_data=8'h01; out_valid high exactly one cycle, rising after edge 5; no second emission.
2. Pair 6D/79 for 2 cycles, then 4F/47 held → only 8'hEF emitted; no event for 8'h23.
3. out_ready=0: pair 77/5B qualifies → out_data=8'hA5 held. Then pair 79/4E qualifies → out_data stays A5, overrun=1. Raise out_ready → one transfer of A5, out_valid=0.
4. input_segment2=7E, input_segment1=01 held → err_pulse one cycle, err_mask=2'b01, out_valid stays 0. Both 00 held → no pulse, no data.
5. Reset asserted at counter=2 with pair 30/30 applied, then released with 30/30 still applied → all outputs 0 during reset; 8'h11 emitted 5 edges after release.
6. With SEG_ACTIVE_LOW_EN: input_segment2=00, input_segment1=01 → out_data=8'h80. Both 7F → ignored.
